// File: rtl/cfg_frame_loader.sv
// Serial bitstream loader: hunts a sync word, stages one tile/switch-box frame,
// and applies lut/ff/sb config atomically only when the XOR checksum matches.
module cfg_frame_loader #(
    parameter logic [7:0] SYNC_WORD = 8'hA5,
    parameter int         LUT_W     = 32,
    parameter int         SB_W      = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [LUT_W-1:0] lut_cfg,
    output logic             ff_sel,
    output logic [SB_W-1:0]  sb_cfg,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int P  = LUT_W + 8 + SB_W;
    localparam int NB = P / 8;
    localparam int CW = $clog2(P);

    typedef enum logic [1:0] {IDLE, SYNC, PAYLOAD, CHECK} state_t;

    state_t         state;
    state_t         state_nx;
    logic [7:0]     hunt;
    logic [7:0]     chk;
    logic [P-1:0]   stage;
    logic [CW-1:0]  cnt;
    logic           apply;

    logic [7:0]     hunt_nx;
    logic [7:0]     chk_nx;
    logic [7:0]     sum;
    logic           sync_hit;
    logic           last_pay;
    logic           last_chk;
    logic           good;
    logic           bad;

    assign hunt_nx = {hunt[6:0], bit_in};
    assign chk_nx  = {chk[6:0], bit_in};
    assign busy    = (state != IDLE);
    assign good    = last_chk && (chk_nx == sum);
    assign bad     = last_chk && (chk_nx != sum);

    always_comb begin
        sum = '0;
        for (int i = 0; i < NB; i++) begin
            sum = sum ^ stage[i*8 +: 8];
        end
    end

    always_comb begin
        state_nx = state;
        sync_hit = 1'b0;
        last_pay = 1'b0;
        last_chk = 1'b0;
        if (start) begin
            state_nx = SYNC;
        end else if (bit_valid) begin
            unique case (state)
                IDLE: ;
                SYNC: begin
                    if (hunt_nx == SYNC_WORD) begin
                        sync_hit = 1'b1;
                        state_nx = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (cnt == CW'(P - 1)) begin
                        last_pay = 1'b1;
                        state_nx = CHECK;
                    end
                end
                CHECK: begin
                    if (cnt == CW'(7)) begin
                        last_chk = 1'b1;
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // apply is committed on the last checksum bit; a later start cannot cancel it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hunt    <= '0;
            chk     <= '0;
            stage   <= '0;
            cnt     <= '0;
            apply   <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            lut_cfg <= '0;
            ff_sel  <= 1'b0;
            sb_cfg  <= '0;
        end else begin
            apply <= good;
            done  <= apply;
            if (apply) begin
                lut_cfg <= stage[P-1 -: LUT_W];
                ff_sel  <= stage[SB_W];
                sb_cfg  <= stage[SB_W-1:0];
            end
            if (start) begin
                hunt  <= '0;
                cnt   <= '0;
                error <= 1'b0;
            end else if (bit_valid) begin
                unique case (state)
                    IDLE: ;
                    SYNC: begin
                        hunt <= hunt_nx;
                        if (sync_hit) cnt <= '0;
                    end
                    PAYLOAD: begin
                        stage <= {stage[P-2:0], bit_in};
                        cnt   <= last_pay ? '0 : cnt + 1'b1;
                    end
                    CHECK: begin
                        chk <= chk_nx;
                        cnt <= last_chk ? '0 : cnt + 1'b1;
                        if (bad) error <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Randomized bench for cfg_frame_loader: a queue-based frame model predicts
// every output each cycle, plus hand-computed literal checks on key frames.
module tb_cfg_frame_loader;

    localparam int P = 56;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic [31:0] lut_cfg;
    logic        ff_sel;
    logic [15:0] sb_cfg;
    logic        busy;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail = 0;

    cfg_frame_loader dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .bit_in   (bit_in),
        .bit_valid(bit_valid),
        .lut_cfg  (lut_cfg),
        .ff_sel   (ff_sel),
        .sb_cfg   (sb_cfg),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bits since start are kept in a queue; the frame is
    // judged as a whole once sync plus payload plus checksum have arrived.
    logic [31:0] m_lut = '0;
    logic        m_ff = 1'b0;
    logic [15:0] m_sb = '0;
    logic        m_done = 1'b0;
    logic        m_err = 1'b0;
    logic        m_armed = 1'b0;
    logic        m_synced = 1'b0;
    logic        m_pend = 1'b0;
    logic [31:0] m_pl = '0;
    logic        m_pf = 1'b0;
    logic [15:0] m_ps = '0;
    logic        q[$];
    logic [7:0]  m_by[8];
    logic [7:0]  m_tail;
    logic [7:0]  m_x;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_lut = '0; m_ff = 0; m_sb = '0; m_done = 0; m_err = 0;
            m_armed = 0; m_synced = 0; m_pend = 0;
            q.delete();
        end else begin
            m_done = 0;
            if (m_pend) begin
                m_lut = m_pl; m_ff = m_pf; m_sb = m_ps;
                m_done = 1; m_pend = 0;
            end
            if (start) begin
                m_armed = 1; m_synced = 0; m_err = 0;
                q.delete();
            end else if (m_armed && bit_valid) begin
                q.push_back(bit_in);
                if (!m_synced) begin
                    if (q.size() >= 8) begin
                        m_tail = '0;
                        for (int i = 0; i < 8; i++)
                            m_tail = {m_tail[6:0], q[q.size() - 8 + i]};
                        if (m_tail == 8'hA5) begin
                            m_synced = 1;
                            q.delete();
                        end
                    end
                end else if (q.size() == P + 8) begin
                    for (int k = 0; k < 8; k++) begin
                        m_by[k] = '0;
                        for (int i = 0; i < 8; i++)
                            m_by[k] = {m_by[k][6:0], q[8*k + i]};
                    end
                    m_x = '0;
                    for (int k = 0; k < 7; k++) m_x = m_x ^ m_by[k];
                    if (m_x == m_by[7]) begin
                        m_pend = 1;
                        m_pl = {m_by[0], m_by[1], m_by[2], m_by[3]};
                        m_pf = m_by[4][0];
                        m_ps = {m_by[5], m_by[6]};
                    end else begin
                        m_err = 1;
                    end
                    m_armed = 0; m_synced = 0;
                    q.delete();
                end
            end
        end
    end

    always @(negedge clock) begin
        check("outputs", {12'h0, lut_cfg, ff_sel, sb_cfg, busy, done, error},
              {12'h0, m_lut, m_ff, m_sb, m_armed, m_done, m_err});
    end

    function automatic logic [7:0] frame_xor(input logic [55:0] p);
        logic [7:0] x = '0;
        for (int k = 0; k < 7; k++) x = x ^ p[8*k +: 8];
        return x;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int mode);
        int gap;
        gap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
        bit_in = b;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
        bit_in = 1'($urandom);
        repeat (gap) tick();
    endtask

    task automatic send_bits(input logic [63:0] v, input int n, input int mode);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i], mode);
    endtask

    task automatic send_frame(input logic [55:0] pay, input logic [7:0] ck,
                              input int mode);
        send_bits(64'hA5, 8, mode);
        send_bits({8'h0, pay}, P, mode);
        send_bits({56'h0, ck}, 8, mode);
    endtask

    initial begin
        logic [63:0] r;
        logic [55:0] pay;
        logic [7:0]  ck;
        logic [17:0] s;
        logic [9:0]  g;
        logic        ok;
        int          mode;

        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check("reset_cfg", {lut_cfg, ff_sel, sb_cfg}, '0);
        check("reset_flags", {busy, done, error}, '0);

        for (int i = 0; i < 12; i++) send_bit(1'($urandom), 0);
        check("idle_ignores_bits", busy, 0);

        check("xor_good", frame_xor(56'h80000001018421), 8'h25);
        check("xor_dead", frame_xor(56'hDEADBEEF0000FF), 8'hDD);

        // Good frame
        pulse_start();
        send_frame(56'h80000001018421, 8'h25, 0);
        check("good_latency", done, 0);
        tick();
        check("good_lut", lut_cfg, 32'h80000001);
        check("good_ff", ff_sel, 1);
        check("good_sb", sb_cfg, 16'h8421);
        check("good_flags", {busy, done, error}, 3'b010);
        tick();
        check("good_done_width", done, 0);

        // Bad checksum
        pulse_start();
        send_frame(56'h80000001018421, 8'h24, 0);
        repeat (3) tick();
        check("bad_error", error, 1);
        check("bad_cfg_kept", {lut_cfg, ff_sel, sb_cfg}, {32'h80000001, 1'b1, 16'h8421});
        pulse_start();
        check("start_clears_error", {busy, error}, 2'b10);

        // Sync hunt through noise with gaps
        do begin
            g = 10'($urandom);
            s = {g, 8'hA5};
            ok = 1'b1;
            for (int j = 0; j < 10; j++)
                if (s[17 - j -: 8] == 8'hA5) ok = 1'b0;
        end while (!ok);
        r = {$urandom, $urandom};
        pay = r[55:0];
        pulse_start();
        send_bits({54'h0, g}, 10, 1);
        send_frame(pay, frame_xor(pay), 1);
        repeat (3) tick();
        check("hunt_cfg", {lut_cfg, ff_sel, sb_cfg}, {pay[55:24], pay[16], pay[15:0]});
        check("hunt_error", error, 0);

        // Abort mid-payload
        pulse_start();
        send_bits(64'hA5, 8, 0);
        send_bits(64'hFFFFF, 20, 0);
        pulse_start();
        send_frame(56'hDEADBEEF0000FF, frame_xor(56'hDEADBEEF0000FF), 0);
        tick();
        check("abort_cfg", {lut_cfg, ff_sel, sb_cfg}, {32'hDEADBEEF, 1'b0, 16'h00FF});
        check("abort_done", done, 1);

        // Start in the cycle the apply happens
        pulse_start();
        send_frame(56'h12345678_01A5C3, frame_xor(56'h12345678_01A5C3), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("collide_cfg", {lut_cfg, ff_sel, sb_cfg}, {32'h12345678, 1'b1, 16'hA5C3});
        check("collide_flags", {busy, done}, 2'b11);

        // Randomized frames
        for (int it = 0; it < 40; it++) begin
            r = {$urandom, $urandom};
            pay = r[55:0];
            ck = frame_xor(pay);
            if ($urandom_range(0, 3) == 0) ck = ck ^ 8'($urandom_range(1, 255));
            mode = int'($urandom_range(0, 2));
            if ($urandom_range(0, 4) == 0) begin
                pulse_start();
                send_bits(64'hA5, 8, mode);
                send_bits({$urandom, $urandom}, int'($urandom_range(0, 60)), mode);
            end
            pulse_start();
            send_bits({$urandom, $urandom}, int'($urandom_range(0, 6)), mode);
            send_frame(pay, ck, mode);
            repeat ($urandom_range(0, 2)) tick();
        end

        // Asynchronous reset mid-payload
        pulse_start();
        send_frame(56'h80000001018421, 8'h25, 0);
        repeat (2) tick();
        pulse_start();
        send_bits(64'hA5, 8, 0);
        send_bits(64'h5A5A5, 20, 0);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_cfg", {lut_cfg, ff_sel, sb_cfg}, '0);
        check("async_reset_flags", {busy, done, error}, '0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) send_bit(1'($urandom), 0);
        check("post_reset_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
